// File: rtl/clock_apb_initiator_if.sv
// Command, response and APB signal bundle for the clock-node APB initiator.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface clock_apb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/clock_apb_initiator.sv
// Single-outstanding APB initiator for clock-node register windows.
// One valid/ready command becomes one SETUP+ACCESS transfer and one response.
module clock_apb_initiator #(
  parameter int unsigned TIMEOUT = 256,  // 0 disables the ACCESS-phase timeout
  parameter int unsigned CNT_W   = 16    // TIMEOUT must fit below 2**CNT_W
) (
  input  logic                  clock,
  input  logic                  async_resetn,
  clock_apb_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam bit               TO_EN     = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_slverr  <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is registered, so the first IDLE cycle after reset only raises it
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.pwrite    <= bus.cmd_write;
            bus.paddr     <= bus.cmd_addr & ~32'h3;
            bus.pwdata    <= bus.cmd_wdata;
            bus.cmd_ready <= 1'b0;
            bus.psel      <= 1'b1;
            state         <= SETUP;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        SETUP: begin
          bus.penable <= 1'b1;
          wait_cnt    <= '0;
          state       <= ACCESS;
        end

        ACCESS: begin
          // pready wins over the timeout when both land in the same cycle
          if (bus.pready) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_rdata   <= bus.pwrite ? 32'h0 : bus.prdata;
            bus.rsp_slverr  <= bus.pslverr;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else if (TO_EN && (wait_cnt == WAIT_LAST)) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_slverr  <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_apb_initiator.sv
// Randomized bench for clock_apb_initiator: transaction-level expectations
// (latency, framing, response fields) derived from wait-state count and TIMEOUT.
module tb_clock_apb_initiator;
  localparam int unsigned T = 8;

  logic clock = 1'b0;
  logic async_resetn = 1'b0;

  clock_apb_initiator_if bus();

  clock_apb_initiator #(.TIMEOUT(T), .CNT_W(16)) dut (
    .clock        (clock),
    .async_resetn (async_resetn),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  // One complete transfer; caller sits at a negedge. waits = pready-low ACCESS cycles
  // before the slave answers, rdly = cycles rsp_ready is withheld.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] prd, input logic slv, input int waits, input int rdly);
    logic        to;
    int          acc;
    int          guard;
    logic [31:0] exp_rd;
    logic        exp_slv;
    logic [31:0] exp_paddr;
    to        = (T != 0) && (waits >= int'(T));
    acc       = to ? int'(T) : waits + 1;
    exp_rd    = (to || wr) ? 32'h0 : prd;
    exp_slv   = to ? 1'b1 : slv;
    exp_paddr = {addr[31:2], 2'b00};

    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    chk("cmd_ready_idle", {31'h0, bus.cmd_ready}, 32'h1);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(posedge clock);
    #1;
    // garbage on the command port while busy must be ignored
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;

    @(negedge clock);
    chk("setup_psel",    {31'h0, bus.psel},    32'h1);
    chk("setup_penable", {31'h0, bus.penable}, 32'h0);
    chk("setup_paddr",   bus.paddr, exp_paddr);
    chk("setup_pwrite",  {31'h0, bus.pwrite},  {31'h0, wr});
    chk("setup_pwdata",  bus.pwdata, wdata);
    chk("setup_cmd_rdy", {31'h0, bus.cmd_ready}, 32'h0);
    bus.pready  = 1'($urandom);
    bus.prdata  = $urandom;
    bus.pslverr = 1'($urandom);

    for (int k = 0; k < acc; k++) begin
      @(negedge clock);
      chk("access_psel",    {31'h0, bus.psel},      32'h1);
      chk("access_penable", {31'h0, bus.penable},   32'h1);
      chk("access_rspv",    {31'h0, bus.rsp_valid}, 32'h0);
      chk("access_paddr",   bus.paddr,  exp_paddr);
      chk("access_pwdata",  bus.pwdata, wdata);
      bus.pready  = (k == waits);
      bus.prdata  = (k == waits) ? prd : $urandom;
      bus.pslverr = (k == waits) ? slv : 1'($urandom);
    end

    @(negedge clock);
    chk("resp_valid",   {31'h0, bus.rsp_valid},   32'h1);
    chk("resp_psel",    {31'h0, bus.psel},        32'h0);
    chk("resp_penable", {31'h0, bus.penable},     32'h0);
    chk("resp_rdata",   bus.rsp_rdata, exp_rd);
    chk("resp_slverr",  {31'h0, bus.rsp_slverr},  {31'h0, exp_slv});
    chk("resp_timeout", {31'h0, bus.rsp_timeout}, {31'h0, to});
    chk("resp_paddr",   bus.paddr, exp_paddr);
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'($urandom);  // late pready must not disturb the response
    bus.prdata    = $urandom;

    for (int d = 0; d < rdly; d++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = $urandom;
      @(negedge clock);
      chk("hold_valid",   {31'h0, bus.rsp_valid},   32'h1);
      chk("hold_rdata",   bus.rsp_rdata, exp_rd);
      chk("hold_slverr",  {31'h0, bus.rsp_slverr},  {31'h0, exp_slv});
      chk("hold_timeout", {31'h0, bus.rsp_timeout}, {31'h0, to});
      chk("hold_psel",    {31'h0, bus.psel},        32'h0);
      chk("hold_cmd_rdy", {31'h0, bus.cmd_ready},   32'h0);
      bus.pready = 1'($urandom);
      bus.prdata = $urandom;
    end

    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    @(negedge clock);
    chk("done_rspv",    {31'h0, bus.rsp_valid}, 32'h0);
    chk("done_cmd_rdy", {31'h0, bus.cmd_ready}, 32'h1);
    chk("done_psel",    {31'h0, bus.psel},      32'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, {31'h0, bus.cmd_ready},   32'h0);
    chk({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid},   32'h0);
    chk({tag, "_psel"},      {31'h0, bus.psel},        32'h0);
    chk({tag, "_penable"},   {31'h0, bus.penable},     32'h0);
    chk({tag, "_rdata"},     bus.rsp_rdata,            32'h0);
    chk({tag, "_slverr"},    {31'h0, bus.rsp_slverr},  32'h0);
    chk({tag, "_timeout"},   {31'h0, bus.rsp_timeout}, 32'h0);
    chk({tag, "_paddr"},     bus.paddr,                32'h0);
    chk({tag, "_pwdata"},    bus.pwdata,               32'h0);
    chk({tag, "_pwrite"},    {31'h0, bus.pwrite},      32'h0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    repeat (3) @(negedge clock);
    chk_reset_vals("rst");
    async_resetn = 1'b1;
    @(negedge clock);
    chk("rst_release_cmd_rdy", {31'h0, bus.cmd_ready}, 32'h1);

    xfer(1'b0, 32'h08, 32'h0,        32'h05F5E100, 1'b0, 0, 0);
    xfer(1'b1, 32'h34, 32'h12345678, 32'hDEADBEEF, 1'b0, 3, 0);
    xfer(1'b0, 32'h4B, 32'h0,        32'hCAFE0001, 1'b1, 0, 0);
    xfer(1'b0, 32'h20, 32'h0,        32'h11112222, 1'b0, 20, 1);
    xfer(1'b1, 32'h24, 32'hA5A5A5A5, 32'h0,        1'b0, int'(T), 0);
    xfer(1'b0, 32'h28, 32'h0,        32'h33334444, 1'b0, int'(T) - 1, 0);
    xfer(1'b0, 32'h40, 32'h0,        32'h55556666, 1'b0, 1, 5);

    // reset in the middle of ACCESS, away from any clock edge
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h10;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    bus.pready = 1'b0;
    repeat (3) @(negedge clock);
    chk("pre_rst_penable", {31'h0, bus.penable}, 32'h1);
    #2 async_resetn = 1'b0;
    #1;
    chk("async_rst_psel",    {31'h0, bus.psel},      32'h0);
    chk("async_rst_penable", {31'h0, bus.penable},   32'h0);
    chk("async_rst_rspv",    {31'h0, bus.rsp_valid}, 32'h0);
    chk("async_rst_cmd_rdy", {31'h0, bus.cmd_ready}, 32'h0);
    @(negedge clock);
    async_resetn = 1'b1;
    @(negedge clock);
    chk("rerelease_cmd_rdy", {31'h0, bus.cmd_ready}, 32'h1);
    xfer(1'b0, 32'h0C, 32'h0, 32'h0BADF00D, 1'b0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
           $urandom_range(0, 10), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clock_apb_initiator.md
Name: clock_apb_initiator

Overview:
- Single-outstanding APB initiator that drives clock-node register interfaces, including the base register file and the pass-through sub-module window.
- Converts a valid/ready command (read/write, address, data) into a standard two-phase APB transfer (SETUP then ACCESS).
- Waits for pready, then returns read data, slave error and timeout status on a valid/ready response channel.
- Sits between the clock-tree management controller and the clock-node slaves.

Parameters:
TIMEOUT, 256, max ACCESS-phase cycles with pready low before abort; 0 disables timeout
CNT_W, 16, width of wait counter; TIMEOUT must be < 2^CNT_W

Ports:
clock  input  1  single clock; all logic rising-edge
async_resetn  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  32  byte address
cmd_wdata  input  32  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  32  read data; 0 for writes and aborted transfers
rsp_slverr  output  1  pslverr sampled with pready, or timeout
rsp_timeout  output  1  transfer aborted by timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  32  APB address, bits [1:0] forced 0
pwdata  output  32  APB write data
prdata  input  32  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- All outputs registered. Reset values: cmd_ready 0, rsp_valid 0, rsp_rdata 0, rsp_slverr 0, rsp_timeout 0, psel 0, penable 0, pwrite 0, paddr 0, pwdata 0, state IDLE, wait_cnt 0.
- Asserting async_resetn low forces all of the above immediately, from any state.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid: latch cmd_write, cmd_addr with [1:0]=0, and cmd_wdata into pwrite/paddr/pwdata; set cmd_ready=0, psel=1; go to SETUP.
  - SETUP (exactly 1 cycle): psel=1, penable=0. Next cycle: penable=1, wait_cnt=0, go to ACCESS.
  - ACCESS, pready=1: go to RESP. Drop psel/penable. Capture rsp_rdata = write ? 0 : prdata, rsp_slverr = pslverr, rsp_timeout = 0. Set rsp_valid = 1.
  - ACCESS, pready=0 and TIMEOUT != 0 and wait_cnt == TIMEOUT-1: abort. Drop psel/penable. Set rsp_rdata=0, rsp_slverr=1, rsp_timeout=1, rsp_valid=1; go to RESP.
  - ACCESS, pready=0 otherwise: wait_cnt += 1; stay in ACCESS.
  - pready=1 takes priority over timeout in the same cycle.
  - RESP: rsp_valid held with rsp_* stable until rsp_ready. On handshake: rsp_valid=0, cmd_ready=1, go to IDLE.
- pwrite/paddr/pwdata are stable from SETUP until the transfer completes. They hold their last value in IDLE/RESP; only psel/penable frame the transfer.
- Latency with zero wait states: command handshake in cycle N, SETUP in N+1, ACCESS in N+2, rsp_valid in N+3.
- Each pready-low cycle adds 1 cycle.
- Minimum command-to-command spacing is 4 cycles; psel is low for at least one cycle between transfers. No pipelining; one transfer outstanding.
- cmd_* inputs are ignored while cmd_ready=0.
- Timeout with TIMEOUT=T: psel drops after exactly T ACCESS cycles with pready low. A late pready after the abort is ignored.
- wait_cnt saturates logically; it never wraps, because the abort fires at TIMEOUT-1.
- TIMEOUT=0: waits indefinitely.

Test Plan:
- Read 0x08, pready tied 1, prdata=0x05F5E100 -> psel@N+1, penable@N+2, rsp_valid@N+3, rsp_rdata=0x05F5E100, slverr=0, timeout=0.
- Write 0x34 data 0x12345678, pready low 3 ACCESS cycles -> penable high 4 cycles, pwrite=1, paddr=0x34, pwdata stable; rsp_valid@N+6, rsp_rdata=0.
- Read with pready=1, pslverr=1 -> rsp_slverr=1, rsp_timeout=0, rsp_rdata=prdata; misaligned cmd_addr 0x4B drives paddr=0x48.
- TIMEOUT=8, pready held 0 -> psel/penable drop after 8 ACCESS cycles; rsp_timeout=1, rsp_slverr=1, rsp_rdata=0; pready pulsed afterward has no effect.
- rsp_ready low 5 cycles with cmd_valid held high and new address -> rsp_* stable, cmd_ready=0, no new psel. After handshake: cmd_ready=1 next cycle, new transfer starts.
- async_resetn low mid-ACCESS -> psel, penable, rsp_valid 0 without waiting for a clock edge. After release: IDLE, cmd_ready=1 next edge, next read completes normally.
